// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy encoding and default payload widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int PIPE_DATA_W = 40;
    localparam int PIPE_CTRL_W = 20;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid flag plus control and data payload registers.
// Latency: load/clear take effect at the next clock edge.
// Backpressure: none; the owner decides when to load or clear.
module pipe_entry #(
    parameter int CTRL_W = 20,
    parameter int DATA_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic              clr_data,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Clear wins over load; control is zeroed on every clear so an empty
    // slot never presents live enables, data is zeroed only on request.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (clr_data) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with a one-entry skid buffer and flush support.
// Latency: 1 cycle from accept to out_* when the main slot is empty or emitting.
// Backpressure: in_ready is registered (!skid valid); skid absorbs one extra beat.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W            = PIPE_DATA_W,
    parameter int CTRL_W            = PIPE_CTRL_W,
    parameter int CLR_DATA_ON_FLUSH = 1,
    parameter int STALL_CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic FLUSH_CLR_DATA = (CLR_DATA_ON_FLUSH != 0);

    occ_t              occ;
    occ_t              occ_nxt;
    logic              accept;
    logic              emit;
    logic              main_load;
    logic              main_clr;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clr;
    logic              clr_data;
    logic              skid_vld;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_dat;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_dat;

    assign in_ready     = !skid_vld;
    assign accept       = in_valid && in_ready;
    assign emit         = out_valid && out_ready;
    assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_ld_dat  = main_from_skid ? skid_dat  : in_data;

    // Occupancy transitions and slot controls; flush overrides any handshake.
    always_comb begin
        occ_nxt        = occ;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        clr_data       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            clr_data = FLUSH_CLR_DATA;
            occ_nxt  = EMPTY;
        end else begin
            unique case (occ)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        occ_nxt   = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        occ_nxt   = FULL;
                    end else if (emit) begin
                        main_clr = 1'b1;
                        occ_nxt  = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        occ_nxt        = ONE;
                    end
                end
                default: begin
                    occ_nxt = EMPTY;
                end
            endcase
        end
    end

    // Occupancy register; reset dominates flush and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= EMPTY;
        end else begin
            occ <= occ_nxt;
        end
    end

    // Saturating count of cycles where a live output is held by downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .clr      (main_clr),
        .clr_data (clr_data),
        .ld_ctrl  (main_ld_ctrl),
        .ld_data  (main_ld_dat),
        .valid    (out_valid),
        .ctrl     (out_ctrl),
        .data     (out_data)
    );

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clr      (skid_clr),
        .clr_data (clr_data),
        .ld_ctrl  (in_ctrl),
        .ld_data  (in_data),
        .valid    (skid_vld),
        .ctrl     (skid_ctrl),
        .data     (skid_dat)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two builds (defaults, and retain-data/4-bit counter)
// share one stimulus stream and are checked every cycle against a queue model,
// plus literal expectations at key points of each directed scenario.
module tb_pipe_stage_skid;

    localparam int DW = 40;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [7:0]    a_stall;

    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [3:0]    b_stall;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W (DW), .CTRL_W (CW), .CLR_DATA_ON_FLUSH (1), .STALL_CNT_W (8)
    ) dut_a (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (a_in_ready),
        .in_ctrl (in_ctrl), .in_data (in_data),
        .out_valid (a_out_valid), .out_ready (out_ready),
        .out_ctrl (a_out_ctrl), .out_data (a_out_data),
        .stall_cnt (a_stall)
    );

    pipe_stage_skid #(
        .DATA_W (DW), .CTRL_W (CW), .CLR_DATA_ON_FLUSH (0), .STALL_CNT_W (4)
    ) dut_b (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (b_in_ready),
        .in_ctrl (in_ctrl), .in_data (in_data),
        .out_valid (b_out_valid), .out_ready (out_ready),
        .out_ctrl (b_out_ctrl), .out_data (b_out_data),
        .stall_cnt (b_stall)
    );

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    item_t         q[$];          // items held by the stage, oldest first
    logic [DW-1:0] emit_log[$];   // data seen leaving dut_a
    int            m_cnt_a = 0;
    int            m_cnt_b = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model update for one clock edge, using the inputs and state held before it.
    task automatic model_edge();
        bit    acc;
        bit    emt;
        item_t it;
        acc = in_valid && (q.size() < 2);
        emt = (q.size() > 0) && out_ready;
        if (rst) begin
            q.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            if ((q.size() > 0) && !out_ready) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 15)  m_cnt_b++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (emt) void'(q.pop_front());
                if (acc) begin
                    it.c = in_ctrl;
                    it.d = in_data;
                    q.push_back(it);
                end
            end
        end
    endtask

    // Per-cycle comparison of both builds against the model.
    task automatic compare_all();
        bit            v;
        logic [CW-1:0] ec;
        v  = (q.size() > 0);
        ec = v ? q[0].c : '0;
        chk("a_out_valid", 64'(a_out_valid), 64'(v));
        chk("b_out_valid", 64'(b_out_valid), 64'(v));
        chk("a_in_ready",  64'(a_in_ready),  64'(q.size() < 2));
        chk("b_in_ready",  64'(b_in_ready),  64'(q.size() < 2));
        chk("a_out_ctrl",  64'(a_out_ctrl),  64'(ec));
        chk("b_out_ctrl",  64'(b_out_ctrl),  64'(ec));
        if (v) begin
            chk("a_out_data", 64'(a_out_data), 64'(q[0].d));
            chk("b_out_data", 64'(b_out_data), 64'(q[0].d));
        end
        chk("a_stall_cnt", 64'(a_stall), 64'(m_cnt_a));
        chk("b_stall_cnt", 64'(b_stall), 64'(m_cnt_b));
    endtask

    task automatic step();
        if (a_out_valid && out_ready && !rst) emit_log.push_back(a_out_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = {4'hC, d[15:0]};
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_out_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("rst_out_data",  64'(a_out_data),  64'd0);
        chk("rst_stall",     64'(a_stall),     64'd0);
        rst = 1'b0;

        // Streaming at full rate
        emit_log.delete();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, DW'(k), 1'b1, 1'b0);
            step();
            chk("stream_data",  64'(a_out_data), 64'(k));
            chk("stream_ready", 64'(a_in_ready), 64'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("stream_drained", 64'(a_out_valid), 64'd0);
        chk("stream_stall",   64'(a_stall),     64'd0);
        chk("stream_count",   64'(emit_log.size()), 64'd4);
        for (int i = 0; i < emit_log.size(); i++)
            chk("stream_order", 64'(emit_log[i]), 64'(i + 1));

        // Backpressure into the skid slot
        emit_log.delete();
        drive(1'b1, 40'hA1, 1'b0, 1'b0);
        step();
        chk("bp_first",  64'(a_out_data), 64'hA1);
        chk("bp_rdy1",   64'(a_in_ready), 64'd1);
        drive(1'b1, 40'hA2, 1'b0, 1'b0);
        step();
        chk("bp_hold",   64'(a_out_data), 64'hA1);
        chk("bp_rdy0",   64'(a_in_ready), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) step();
        chk("bp_stall",  64'(a_stall), 64'd4);
        chk("bp_stable", 64'(a_out_ctrl), 64'hC00A1);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("bp_second", 64'(a_out_data), 64'hA2);
        chk("bp_rdy_back", 64'(a_in_ready), 64'd1);
        step();
        chk("bp_count",  64'(emit_log.size()), 64'd2);
        if (emit_log.size() == 2) begin
            chk("bp_emit0", 64'(emit_log[0]), 64'hA1);
            chk("bp_emit1", 64'(emit_log[1]), 64'hA2);
        end

        // Flush while FULL with a concurrent offer
        emit_log.delete();
        drive(1'b1, 40'hB1, 1'b0, 1'b0); step();
        drive(1'b1, 40'hB2, 1'b0, 1'b0); step();
        drive(1'b1, 40'hB3, 1'b0, 1'b1); step();
        chk("fl_valid", 64'(a_out_valid), 64'd0);
        chk("fl_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("fl_data",  64'(a_out_data),  64'd0);
        chk("fl_ready", 64'(a_in_ready),  64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step();
        chk("fl_nothing_emitted", 64'(emit_log.size()), 64'd0);

        // Flush in the data-retaining build
        drive(1'b1, 40'h55, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b1); step();
        chk("keep_valid", 64'(b_out_valid), 64'd0);
        chk("keep_ctrl",  64'(b_out_ctrl),  64'd0);
        chk("keep_data",  64'(b_out_data),  64'h55);
        chk("clr_data",   64'(a_out_data),  64'd0);

        // Flush coinciding with an emit
        emit_log.delete();
        drive(1'b1, 40'h66, 1'b1, 1'b0); step();
        drive(1'b0, '0, 1'b1, 1'b1); step();
        chk("flemit_valid", 64'(a_out_valid), 64'd0);
        chk("flemit_ready", 64'(a_in_ready),  64'd1);
        chk("flemit_taken", 64'(emit_log.size()), 64'd1);

        // Long stall: 4-bit counter saturates, 8-bit keeps counting
        drive(1'b1, 40'h77, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (20) step();
        chk("sat_b",   64'(b_stall), 64'd15);
        chk("count_a", 64'(a_stall), 64'd27);
        drive(1'b0, '0, 1'b0, 1'b1); step();
        chk("sat_b_flush",   64'(b_stall), 64'd15);
        chk("count_a_flush", 64'(a_stall), 64'd28);

        // Reset while FULL, together with flush and an offer
        drive(1'b1, 40'h88, 1'b0, 1'b0); step();
        drive(1'b1, 40'h99, 1'b0, 1'b0); step();
        chk("full_ready", 64'(a_in_ready), 64'd0);
        rst = 1'b1;
        drive(1'b1, 40'hAA, 1'b0, 1'b1); step();
        rst = 1'b0;
        chk("rfull_valid", 64'(a_out_valid), 64'd0);
        chk("rfull_ready", 64'(a_in_ready),  64'd1);
        chk("rfull_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("rfull_data",  64'(a_out_data),  64'd0);
        chk("rfull_bdata", 64'(b_out_data),  64'd0);
        chk("rfull_stall", 64'(b_stall),     64'd0);
        emit_log.delete();
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        step();
        chk("rfull_no_emit", 64'(emit_log.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
